// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Package : sprite_pkg
//  Shared screen geometry, pixel field widths, colour constants and the
//  plot-arbiter state encoding used by the sprite drawing blocks.
//  Rev 1.0 - initial release
// ============================================================================
package sprite_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int C_W      = 3;

  localparam logic [C_W-1:0] COL_BLACK = 3'b000;
  localparam logic [C_W-1:0] COL_ALIEN = 3'b101;

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Next index in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module : rr_pick
//  Combinational round-robin picker: returns the first requester at or after
//  ptr (wrapping), as a one-hot vector and as an index.
//  Ports:
//    req  in  N   request vector
//    ptr  in  IW  priority start index
//    pick out N   one-hot winner (all zero if no request)
//    idx  out IW  winner index
//    any  out 1   at least one request present
//  Rev 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Two passes over a fixed index range: first the entries at or above ptr,
  // then the wrapped-around entries below it.
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        any     = 1'b1;
        pick[i] = 1'b1;
        idx     = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        any     = 1'b1;
        pick[i] = 1'b1;
        idx     = IW'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_plot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : sprite_plot_arbiter
//  Round-robin arbiter between sprite drawers and the VGA adapter. A grant is
//  held for a whole sprite burst; each consumed pixel is registered onto the
//  plot port one cycle later, with off-screen pixels suppressed.
//  Ports:
//    clk        in   1          system clock
//    reset      in   1          asynchronous active-low reset
//    src_req    in   NUM_SRC    drawer i offers a pixel this cycle
//    src_x      in   9*NUM_SRC  packed x, drawer i at [9i+8:9i]
//    src_y      in   8*NUM_SRC  packed y, drawer i at [8i+7:8i]
//    src_colour in   3*NUM_SRC  packed colour, drawer i at [3i+2:3i]
//    src_last   in   NUM_SRC    offered pixel is the last of the sprite
//    src_grant  out  NUM_SRC    one-hot grant; pixel consumed on grant & req
//    vga_x      out  9          plot x
//    vga_y      out  8          plot y
//    vga_colour out  3          plot colour
//    vga_plot   out  1          single-cycle write enable
//    overrun    out  1          sticky, a burst was force-released
//  Rev 1.0 - initial release
// ============================================================================
module sprite_plot_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_SRC   = 3,
  parameter int SCREEN_W  = sprite_pkg::SCREEN_W,
  parameter int SCREEN_H  = sprite_pkg::SCREEN_H,
  parameter int MAX_BURST = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SRC-1:0]     src_req,
  input  logic [X_W*NUM_SRC-1:0] src_x,
  input  logic [Y_W*NUM_SRC-1:0] src_y,
  input  logic [C_W*NUM_SRC-1:0] src_colour,
  input  logic [NUM_SRC-1:0]     src_last,
  output logic [NUM_SRC-1:0]     src_grant,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [C_W-1:0]         vga_colour,
  output logic                   vga_plot,
  output logic                   overrun
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_e           state, state_nxt;
  logic [IW-1:0]        cur, cur_nxt;
  logic [IW-1:0]        rr_ptr, rr_nxt;
  logic [CW-1:0]        burst_cnt, cnt_nxt;
  logic [NUM_SRC-1:0]   grant_nxt;
  logic [X_W-1:0]       x_nxt;
  logic [Y_W-1:0]       y_nxt;
  logic [C_W-1:0]       col_nxt;
  logic                 plot_nxt;
  logic                 ovr_nxt;

  logic [NUM_SRC-1:0]   pick_onehot;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  logic                 sel_req;
  logic                 sel_last;
  logic [X_W-1:0]       sel_x;
  logic [Y_W-1:0]       sel_y;
  logic [C_W-1:0]       sel_col;
  logic                 on_screen;

  rr_pick #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_rr_pick (
    .req  (src_req),
    .ptr  (rr_ptr),
    .pick (pick_onehot),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Pixel mux: select the fields of the drawer currently holding the grant.
  always_comb begin
    sel_req  = 1'b0;
    sel_last = 1'b0;
    sel_x    = '0;
    sel_y    = '0;
    sel_col  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cur == IW'(i)) begin
        sel_req  = src_req[i];
        sel_last = src_last[i];
        sel_x    = src_x[i*X_W +: X_W];
        sel_y    = src_y[i*Y_W +: Y_W];
        sel_col  = src_colour[i*C_W +: C_W];
      end
    end
  end

  // Widened compare so the screen size may exceed the coordinate range.
  assign on_screen = ({1'b0, sel_x} < (X_W+1)'(SCREEN_W)) &&
                     ({1'b0, sel_y} < (Y_W+1)'(SCREEN_H));

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    rr_nxt    = rr_ptr;
    cnt_nxt   = burst_cnt;
    grant_nxt = src_grant;
    x_nxt     = vga_x;
    y_nxt     = vga_y;
    col_nxt   = vga_colour;
    plot_nxt  = 1'b0;
    ovr_nxt   = overrun;

    case (state)
      ST_ARB: begin
        if (pick_any) begin
          state_nxt = ST_BURST;
          grant_nxt = pick_onehot;
          cur_nxt   = pick_idx;
          cnt_nxt   = '0;
        end
      end
      ST_BURST: begin
        if (sel_req) begin
          x_nxt    = sel_x;
          y_nxt    = sel_y;
          col_nxt  = sel_col;
          plot_nxt = on_screen;
          cnt_nxt  = burst_cnt + CW'(1);
          // The MAX_BURST-th pixel is still plotted; only then is the grant forced off.
          if (sel_last || (burst_cnt == CW'(MAX_BURST-1))) begin
            state_nxt = ST_ARB;
            grant_nxt = '0;
            rr_nxt    = IW'(wrap_inc(int'(cur), NUM_SRC));
            if (!sel_last) begin
              ovr_nxt = 1'b1;
            end
          end
        end else begin
          // Drawer went idle mid-sprite: abandon the burst.
          state_nxt = ST_ARB;
          grant_nxt = '0;
          rr_nxt    = IW'(wrap_inc(int'(cur), NUM_SRC));
        end
      end
      default: begin
        state_nxt = ST_ARB;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_ARB;
      cur        <= '0;
      rr_ptr     <= '0;
      burst_cnt  <= '0;
      src_grant  <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur        <= cur_nxt;
      rr_ptr     <= rr_nxt;
      burst_cnt  <= cnt_nxt;
      src_grant  <= grant_nxt;
      vga_x      <= x_nxt;
      vga_y      <= y_nxt;
      vga_colour <= col_nxt;
      vga_plot   <= plot_nxt;
      overrun    <= ovr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_plot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : tb_sprite_plot_arbiter
//  Randomised bench for sprite_plot_arbiter against a transaction-level
//  model (owner / pointer / pixel count) of the arbitration rules.
//  Rev 1.0 - initial release
// ============================================================================
module tb_sprite_plot_arbiter;

  localparam int N    = 3;
  localparam int MAXB = 64;
  localparam int SW   = 320;
  localparam int SH   = 240;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   src_req;
  logic [9*N-1:0] src_x;
  logic [8*N-1:0] src_y;
  logic [3*N-1:0] src_colour;
  logic [N-1:0]   src_last;
  logic [N-1:0]   src_grant;
  logic [8:0]     vga_x;
  logic [7:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;
  logic           overrun;

  always #5 clk = ~clk;

  sprite_plot_arbiter #(
    .NUM_SRC   (N),
    .SCREEN_W  (SW),
    .SCREEN_H  (SH),
    .MAX_BURST (MAXB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .src_req    (src_req),
    .src_x      (src_x),
    .src_y      (src_y),
    .src_colour (src_colour),
    .src_last   (src_last),
    .src_grant  (src_grant),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .overrun    (overrun)
  );

  int errors = 0;
  int checks = 0;

  // Model: who owns the port (-1 = nobody), the next-priority drawer, pixels
  // consumed in the current burst, and the expected registered outputs.
  int m_owner, m_ptr, m_cnt;
  bit m_ovr, m_plot;
  int m_x, m_y, m_c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_ovr = 0; m_plot = 0;
    m_x = 0; m_y = 0; m_c = 0;
  endtask

  // Predict the effect of the next clock edge given the inputs now applied.
  task automatic model_step();
    int g;
    m_plot = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        g = (m_ptr + k) % N;
        if (m_owner < 0 && src_req[g]) begin
          m_owner = g;
          m_cnt   = 0;
        end
      end
    end else begin
      g = m_owner;
      if (src_req[g]) begin
        m_x    = int'(src_x[g*9 +: 9]);
        m_y    = int'(src_y[g*8 +: 8]);
        m_c    = int'(src_colour[g*3 +: 3]);
        m_plot = (m_x < SW) && (m_y < SH);
        m_cnt  = m_cnt + 1;
        if (src_last[g] || m_cnt == MAXB) begin
          if (!src_last[g]) m_ovr = 1;
          m_owner = -1;
          m_ptr   = (g + 1) % N;
        end
      end else begin
        m_owner = -1;
        m_ptr   = (g + 1) % N;
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] eg;
    eg = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    check("grant",   32'(src_grant), eg);
    check("plot",    32'(vga_plot),  32'(m_plot));
    check("overrun", 32'(overrun),   32'(m_ovr));
    check("vga_x",   32'(vga_x),     32'(m_x));
    check("vga_y",   32'(vga_y),     32'(m_y));
    check("colour",  32'(vga_colour), 32'(m_c));
  endtask

  // Random drawer inputs; coordinates lean towards the clip boundaries.
  task automatic drive(input logic [N-1:0] mask, input int req_pct, input int last_pct);
    for (int i = 0; i < N; i++) begin
      src_req[i]  = mask[i] && ($urandom_range(0, 99) < req_pct);
      src_last[i] = ($urandom_range(0, 99) < last_pct);
      src_x[i*9 +: 9] = $urandom_range(0, 1) ? 9'($urandom_range(314, 325))
                                             : 9'($urandom_range(0, 511));
      src_y[i*8 +: 8] = $urandom_range(0, 1) ? 8'($urandom_range(236, 243))
                                             : 8'($urandom_range(0, 255));
      src_colour[i*3 +: 3] = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic run_cycles(input int n, input logic [N-1:0] mask, input int req_pct,
                            input int last_pct);
    for (int i = 0; i < n; i++) begin
      drive(mask, req_pct, last_pct);
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
    end
  endtask

  initial begin
    int waited;
    reset      = 1'b0;
    src_req    = '0;
    src_last   = '0;
    src_x      = '0;
    src_y      = '0;
    src_colour = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b1;

    run_cycles(400, 3'b111, 80, 10);   // mixed bursts, aborts, clipping
    run_cycles(60,  3'b010, 100, 3);   // lone requester re-winning
    run_cycles(300, 3'b111, 100, 0);   // endless streams: forced releases
    run_cycles(200, 3'b111, 60, 20);   // overrun must stay sticky

    // Drive drawer 1 until it has 9 pixels consumed, then reset on pixel 10.
    waited = 0;
    while (!(m_owner == 1 && m_cnt == 9) && waited < 300) begin
      drive(3'b010, 100, 0);
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
      waited++;
    end
    check("reach_pixel10", 32'(waited < 300), 32'd1);
    drive(3'b010, 100, 0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b1;

    drive(3'b111, 100, 10);
    model_step();
    @(posedge clk);
    #1;
    check("first_after_reset", 32'(src_grant), 32'd1);
    check_outputs();

    run_cycles(300, 3'b111, 85, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
